// File: rtl/proc_multicycle.sv
// Multi-cycle core: FETCH/DECODE/EXEC/WB over a req/ack instruction port, internal regfile and ALU.
// Define PROC_CARRY_EN to add the carry flag, the ADDC func (10) and the carry_flag port.
module proc_multicycle #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 16,
  parameter int PC_W   = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              wb_en,
  output logic [3:0]        wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              halted,
  output logic              illegal
`ifdef PROC_CARRY_EN
  ,
  output logic              carry_flag
`endif
);

  localparam int SH_W = $clog2(DATA_W);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT} state_t;
  state_t state_reg, state_next;

  logic [PC_W-1:0]   pc_reg;
  logic [31:0]       ir_reg;
  logic [DATA_W-1:0] regs [16];
  logic [DATA_W-1:0] op_a_reg, op_b_reg;
  logic [3:0]        dest_reg, func_reg;
  logic              is_t_reg, wr_en_reg, illegal_reg;
  logic [3:0]        wb_addr_reg;
  logic [DATA_W-1:0] wb_data_reg;
  logic [DATA_W-1:0] alu_result;
`ifdef PROC_CARRY_EN
  logic              carry_reg, carry_res_reg, carry_upd_reg;
  logic              alu_carry, alu_carry_upd;
`endif

  logic [4:0]        opcode;
  logic [3:0]        func;
  logic              is_ar, is_t, is_halt, func_ok, legal;
  logic [DATA_W-1:0] imm_sext;

  assign opcode   = ir_reg[31:27];
  assign func     = ir_reg[26:23];
  assign is_ar    = (opcode == 5'b00000);
  assign is_t     = (opcode == 5'b00001);
  assign is_halt  = (opcode == 5'b11111);
  assign imm_sext = DATA_W'($signed(ir_reg[18:0]));

  always_comb begin
    func_ok = 1'b0;
    if (is_ar) begin
`ifdef PROC_CARRY_EN
      func_ok = (func <= 4'd10);
`else
      func_ok = (func <= 4'd9);
`endif
    end else if (is_t) begin
      func_ok = (func <= 4'd1);
    end
  end

  assign legal = (is_ar || is_t) && func_ok;

  always_ff @(posedge CLK) begin
    if (RESET) state_reg <= S_FETCH;
    else       state_reg <= state_next;
  end

  // Request and write strobe are masked while RESET is held so a reset cycle shows a quiet bus.
  always_comb begin
    state_next = state_reg;
    imem_req   = 1'b0;
    wb_en      = 1'b0;
    halted     = 1'b0;
    case (state_reg)
      S_FETCH: begin
        imem_req = !RESET;
        if (imem_ack) state_next = S_DECODE;
      end
      S_DECODE: state_next = is_halt ? S_HALT : S_EXEC;
      S_EXEC:   state_next = S_WB;
      S_WB: begin
        wb_en      = wr_en_reg && !RESET;
        state_next = S_FETCH;
      end
      S_HALT:   halted = 1'b1;
      default:  state_next = S_FETCH;
    endcase
  end

  always_comb begin
    alu_result = '0;
`ifdef PROC_CARRY_EN
    alu_carry     = 1'b0;
    alu_carry_upd = 1'b0;
`endif
    if (is_t_reg) begin
      if (func_reg == 4'd0) begin
        alu_result = op_b_reg;
      end else begin
`ifdef PROC_CARRY_EN
        {alu_carry, alu_result} = {1'b0, op_a_reg} + {1'b0, op_b_reg};
        alu_carry_upd = 1'b1;
`else
        alu_result = op_a_reg + op_b_reg;
`endif
      end
    end else begin
      case (func_reg)
`ifdef PROC_CARRY_EN
        4'd0: begin
          {alu_carry, alu_result} = {1'b0, op_a_reg} + {1'b0, op_b_reg};
          alu_carry_upd = 1'b1;
        end
        // Carry out of a + ~b + 1 is the no-borrow flag.
        4'd1: begin
          {alu_carry, alu_result} = {1'b0, op_a_reg} + {1'b0, ~op_b_reg} + (DATA_W+1)'(1);
          alu_carry_upd = 1'b1;
        end
        4'd10: begin
          {alu_carry, alu_result} = {1'b0, op_a_reg} + {1'b0, op_b_reg} + (DATA_W+1)'(carry_reg);
          alu_carry_upd = 1'b1;
        end
`else
        4'd0: alu_result = op_a_reg + op_b_reg;
        4'd1: alu_result = op_a_reg - op_b_reg;
`endif
        4'd2: alu_result = op_a_reg & op_b_reg;
        4'd3: alu_result = op_a_reg | op_b_reg;
        4'd4: alu_result = op_a_reg ^ op_b_reg;
        4'd5: alu_result = ~(op_a_reg | op_b_reg);
        4'd6: alu_result = DATA_W'($signed(op_a_reg) < $signed(op_b_reg));
        4'd7: alu_result = op_a_reg << op_b_reg[SH_W-1:0];
        4'd8: alu_result = op_a_reg >> op_b_reg[SH_W-1:0];
        4'd9: alu_result = $unsigned($signed(op_a_reg) >>> op_b_reg[SH_W-1:0]);
        default: alu_result = '0;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pc_reg      <= '0;
      ir_reg      <= '0;
      op_a_reg    <= '0;
      op_b_reg    <= '0;
      dest_reg    <= '0;
      func_reg    <= '0;
      is_t_reg    <= 1'b0;
      wr_en_reg   <= 1'b0;
      illegal_reg <= 1'b0;
      wb_addr_reg <= '0;
      wb_data_reg <= '0;
`ifdef PROC_CARRY_EN
      carry_reg     <= 1'b0;
      carry_res_reg <= 1'b0;
      carry_upd_reg <= 1'b0;
`endif
    end else begin
      case (state_reg)
        S_FETCH: begin
          if (imem_ack) begin
            ir_reg <= imem_rdata;
            pc_reg <= pc_reg + PC_W'(1);
          end
        end
        S_DECODE: begin
          // T-class rd shares bits [22:19] with rs1, so operand A needs no mux.
          op_a_reg  <= regs[ir_reg[22:19]];
          op_b_reg  <= is_t ? imm_sext : regs[ir_reg[18:15]];
          dest_reg  <= is_t ? ir_reg[22:19] : ir_reg[14:11];
          func_reg  <= func;
          is_t_reg  <= is_t;
          wr_en_reg <= legal;
          if (!legal && !is_halt) illegal_reg <= 1'b1;
        end
        S_EXEC: begin
          if (wr_en_reg) begin
            wb_addr_reg <= dest_reg;
            wb_data_reg <= alu_result;
          end
`ifdef PROC_CARRY_EN
          carry_res_reg <= alu_carry;
          carry_upd_reg <= alu_carry_upd;
`endif
        end
        S_WB: begin
`ifdef PROC_CARRY_EN
          if (wr_en_reg && carry_upd_reg) carry_reg <= carry_res_reg;
`endif
        end
        default: ;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_reg
      always_ff @(posedge CLK) begin
        if (RESET || gi >= NREGS)
          regs[gi] <= '0;
        else if (state_reg == S_WB && wr_en_reg && dest_reg == 4'(gi))
          regs[gi] <= wb_data_reg;
      end
    end
  endgenerate

  assign imem_addr = pc_reg;
  assign wb_addr   = wb_addr_reg;
  assign wb_data   = wb_data_reg;
  assign illegal   = illegal_reg;
`ifdef PROC_CARRY_EN
  assign carry_flag = carry_reg;
`endif

endmodule
